cordic_gain_pipe: RTL and testbench

CORDIC_GAIN_PIPE -- requirements
Module: cordic_gain_pipe

---
 rtl/cordic_gain_pipe.sv | 125 ++++++++++++
 tb/tb_cordic_gain_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_gain_pipe.sv
// 3-stage CORDIC gain (K ~= 0.607253) compensation pipeline with valid/ready flow control.
// Define CORDIC_GAIN_ROUND_EN to add GUARD_BITS guard bits and round-half-up; default truncates (floor).
module cordic_gain_pipe #(
    parameter int CORDIC_WIDTH = 22,
    parameter int GUARD_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    gain_en_i,
    input  logic [CORDIC_WIDTH-1:0] x_i,
    input  logic [CORDIC_WIDTH-1:0] y_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CORDIC_WIDTH-1:0] x_o,
    output logic [CORDIC_WIDTH-1:0] y_o
);

`ifdef CORDIC_GAIN_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam int unsigned CW = unsigned'(CORDIC_WIDTH);
    localparam int unsigned GB = ROUND_EN ? unsigned'(GUARD_BITS) : 0;
    localparam int unsigned SW = CW + 2 + GB;

    // Sign-extend by two bits and append GB fractional zeros.
    function automatic logic signed [SW-1:0] widen(input logic signed [CW-1:0] v);
        return SW'(v) <<< GB;
    endfunction

    function automatic logic signed [SW-1:0] part_hi(input logic signed [SW-1:0] v);
        return (v >>> 1) + (v >>> 4) + (v >>> 5) + (v >>> 7) + (v >>> 8);
    endfunction

    function automatic logic signed [SW-1:0] part_lo(input logic signed [SW-1:0] v);
        return (v >>> 10) + (v >>> 11) + (v >>> 12) + (v >>> 14);
    endfunction

    logic                 v1_q, g1_q;
    logic signed [CW-1:0] x1_q, y1_q;
    logic                 v2_q, g2_q;
    logic signed [SW-1:0] xa_q, xb_q, ya_q, yb_q;
    logic signed [SW-1:0] xa_d, xb_d, ya_d, yb_d;
    logic                 v3_q;
    logic signed [CW-1:0] x3_q, y3_q;
    logic signed [CW-1:0] x3_d, y3_d;
    logic signed [SW-1:0] xs, ys;
    logic signed [SW-1:0] xw, yw;
    logic                 adv;

    // Whole pipe moves as one; it only stalls when the output slot is held.
    assign adv        = !v3_q || out_ready_i;
    assign in_ready_o = adv;

    // S2 partial sums; pass-through samples carry the widened input in the upper slot.
    always_comb begin
        xw   = widen(x1_q);
        yw   = widen(y1_q);
        xa_d = xw;
        ya_d = yw;
        xb_d = '0;
        yb_d = '0;
        if (g1_q) begin
            xa_d = part_hi(xw);
            xb_d = part_lo(xw);
            ya_d = part_hi(yw);
            yb_d = part_lo(yw);
        end
    end

    // S3 final sum, optional rounding, drop guard bits and truncate.
    always_comb begin
        xs = xa_q + xb_q;
        ys = ya_q + yb_q;
`ifdef CORDIC_GAIN_ROUND_EN
        if (g2_q) begin
            xs = xs + (SW'(1) << (GB - 1));
            ys = ys + (SW'(1) << (GB - 1));
        end
`endif
        x3_d = CW'(xs >>> GB);
        y3_d = CW'(ys >>> GB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            g1_q <= 1'b0;
            x1_q <= '0;
            y1_q <= '0;
            v2_q <= 1'b0;
            g2_q <= 1'b0;
            xa_q <= '0;
            xb_q <= '0;
            ya_q <= '0;
            yb_q <= '0;
            v3_q <= 1'b0;
            x3_q <= '0;
            y3_q <= '0;
        end else if (adv) begin
            v1_q <= in_valid_i;
            g1_q <= gain_en_i;
            x1_q <= x_i;
            y1_q <= y_i;
            v2_q <= v1_q;
            g2_q <= g1_q;
            xa_q <= xa_d;
            xb_q <= xb_d;
            ya_q <= ya_d;
            yb_q <= yb_d;
            v3_q <= v2_q;
            x3_q <= x3_d;
            y3_q <= y3_d;
        end
    end

    assign out_valid_o = v3_q;
    assign x_o         = x3_q;
    assign y_o         = y3_q;

endmodule

// File: tb/tb_cordic_gain_pipe.sv
// Scoreboard bench for cordic_gain_pipe: expected values queued on accept, compared on emit.
module tb_cordic_gain_pipe;

    localparam int W = 22;
    localparam int G = 4;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           acc;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         gain_en = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   emits = 0;
    exp_t sb[$];

    cordic_gain_pipe #(.CORDIC_WIDTH(W), .GUARD_BITS(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .gain_en_i  (gain_en),
        .x_i        (x_in),
        .y_i        (y_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .x_o        (x_out),
        .y_o        (y_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    // Reference: sum of the nine floor-shifted terms, optionally with guard bits and rounding.
    function automatic logic [W-1:0] model(input logic [W-1:0] v, input bit g);
        int     sh[9] = '{1, 4, 5, 7, 8, 10, 11, 12, 14};
        longint a;
        longint s;
        if (!g) return v;
        a = longint'($signed(v));
`ifdef CORDIC_GAIN_ROUND_EN
        a = a <<< G;
`endif
        s = 0;
        foreach (sh[i]) s += a >>> sh[i];
`ifdef CORDIC_GAIN_ROUND_EN
        s = (s + (longint'(1) <<< (G - 1))) >>> G;
`endif
        return W'(s);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, evaluate handshakes just after, pop on emit, push on accept.
    task automatic drive_cycle(input bit vld, input bit g, input logic [W-1:0] x, input logic [W-1:0] y,
                               input bit ordy, input bit lat, input bit use_exp,
                               input logic [W-1:0] ex, input logic [W-1:0] ey);
        exp_t e;
        @(negedge clk);
        in_valid  = vld;
        gain_en   = g;
        x_in      = x;
        y_in      = y;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            emits++;
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(emits), 64'(0));
            end else begin
                e = sb.pop_front();
                check("x_out", 64'(x_out), 64'(e.x));
                check("y_out", 64'(y_out), 64'(e.y));
                if (e.lat) check("latency", 64'(cyc - e.acc), 64'(3));
            end
        end
        if (in_valid && in_ready) begin
            e.x   = use_exp ? ex : model(x, g);
            e.y   = use_exp ? ey : model(y, g);
            e.acc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit g, input bit lat);
        drive_cycle(1'b1, g, x, y, 1'b1, lat, 1'b0, '0, '0);
    endtask

    task automatic idle(input bit ordy);
        drive_cycle(1'b0, 1'b0, '0, '0, ordy, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int           e0;
        logic [W-1:0] ex;
        logic [W-1:0] ey;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_x_out", 64'(x_out), 64'(0));
        check("rst_y_out", 64'(y_out), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Exact power-of-two input, identical under both builds.
        drive_cycle(1'b1, 1'b1, W'(1048576), W'(-1048576), 1'b1, 1'b1, 1'b1, W'(636736), W'(-636736));
        repeat (3) idle(1'b1);

        // Tiny operands expose floor vs round-half-up.
`ifdef CORDIC_GAIN_ROUND_EN
        ex = W'(-1);
        ey = W'(1);
`else
        ex = W'(-9);
        ey = W'(0);
`endif
        drive_cycle(1'b1, 1'b1, W'(-1), W'(1), 1'b1, 1'b1, 1'b1, ex, ey);
        repeat (3) idle(1'b1);

        // Back-to-back stream, alternating mode.
        e0 = emits;
        for (int i = 0; i < 10; i++) send(W'($urandom), W'($urandom), (i % 2) == 0, 1'b1);
        repeat (3) idle(1'b1);
        check("stream_count", 64'(emits - e0), 64'(10));

        // Fill three deep, then hold the output.
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, '0);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            if (sb.size() > 0) begin
                check("stall_x_hold", 64'(x_out), 64'(sb[0].x));
                check("stall_y_hold", 64'(y_out), 64'(sb[0].y));
            end else begin
                check("stall_sb_size", 64'(sb.size()), 64'(3));
            end
        end
        e0 = emits;
        repeat (3) idle(1'b1);
        check("stall_drain", 64'(emits - e0), 64'(3));

        // Reset with two samples in flight.
        for (int i = 0; i < 2; i++)
            drive_cycle(1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, '0, '0);
        idle(1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'(0));
        check("rst_async_x", 64'(x_out), 64'(0));
        check("rst_async_y", 64'(y_out), 64'(0));
        check("rst_async_ready", 64'(in_ready), 64'(1));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("no_stale_out", 64'(out_valid), 64'(0));
        end
        send(W'($urandom), W'($urandom), 1'b1, 1'b1);
        repeat (3) idle(1'b1);

        // Random valid/ready/mode traffic.
        for (int i = 0; i < 60; i++)
            drive_cycle($urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                        $urandom_range(0, 3) != 0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 12; i++) if (sb.size() != 0) idle(1'b1);
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
